crc_chk_serial: RTL and testbench

//  Serial CRC checker: receive side of the serial CRC generator. Takes a MSB-first bitstream
//  of DW data bits immediately followed by PW CRC bits. Recomputes the CRC over the data bits

---
 rtl/crc_chk_serial_if.sv | 27 ++
 rtl/crc_chk_serial.sv | 180 ++++++++++++++++++
 tb/tb_crc_chk_serial.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_chk_serial_if.sv
// Serial CRC checker link: incoming bitstream plus frame results.
// The deserializer side drives the serial inputs, and the checker drives the status and result fields.
interface crc_chk_serial_if #(
  parameter int DW = 8,
  parameter int PW = 8
);
  logic          sin;
  logic          sin_vld;
  logic          sin_sof;
  logic          busy;
  logic          done;
  logic          crc_ok;
  logic          crc_err;
  logic [DW-1:0] rx_data;
  logic [PW-1:0] rx_crc;
  logic [PW-1:0] calc_crc;

  modport master (
    output sin, sin_vld, sin_sof,
    input  busy, done, crc_ok, crc_err, rx_data, rx_crc, calc_crc
  );

  modport slave (
    input  sin, sin_vld, sin_sof,
    output busy, done, crc_ok, crc_err, rx_data, rx_crc, calc_crc
  );
endinterface

// File: rtl/crc_chk_serial.sv
// Serial CRC checker: recomputes the CRC over DW MSB-first data bits and compares it with the PW received CRC bits.
// Optional frame/error/abort statistics are enabled by defining CRC_CHK_STATS_EN.
module crc_chk_serial #(
  parameter int            DW   = 8,
  parameter int            PW   = 8,
  parameter logic [PW-1:0] POLY = 8'h07,
  parameter logic [PW-1:0] INIT = '0
) (
  input  logic                 clk,
  input  logic                 rst_b,
  crc_chk_serial_if.slave      lnk
`ifdef CRC_CHK_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [15:0]          frm_cnt,
  output logic [15:0]          err_cnt,
  output logic [15:0]          abort_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_CRC  = 2'd2;

  localparam int MAXW = (DW > PW) ? DW : PW;
  localparam int CW   = $clog2(MAXW) + 1;

  localparam logic [CW-1:0] CNT_DATA = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_CRC  = CW'(PW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [PW-1:0] lfsr_q,     lfsr_d;
  logic [DW-1:0] rx_data_q,  rx_data_d;
  logic [PW-1:0] rx_crc_q,   rx_crc_d;
  logic [PW-1:0] calc_crc_q, calc_crc_d;
  logic          done_q,     done_d;
  logic          ok_q,       ok_d;
  logic          err_q,      err_d;

  logic [PW-1:0] lfsr_nxt;
  logic [PW-1:0] lfsr_sof;

  function automatic logic [PW-1:0] lfsr_step(input logic [PW-1:0] s, input logic b);
    logic          fb;
    logic [PW-1:0] n;
    fb   = s[PW-1] ^ b;
    n    = '0;
    n[0] = fb;
    for (int unsigned i = 1; i < unsigned'(PW); i++) begin
      n[i] = s[i-1] ^ (POLY[i] & fb);
    end
    return n;
  endfunction

  always_comb begin
    lfsr_nxt   = lfsr_step(lfsr_q, lnk.sin);
    lfsr_sof   = lfsr_step(INIT, lnk.sin);
    state_d    = state_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    rx_data_d  = rx_data_q;
    rx_crc_d   = rx_crc_q;
    calc_crc_d = calc_crc_q;
    done_d     = 1'b0;
    ok_d       = ok_q;
    err_d      = err_q;

    if (lnk.sin_vld) begin
      if (lnk.sin_sof) begin
        // sof restarts from any state; an unfinished frame is dropped without done
        lfsr_d    = lfsr_sof;
        rx_data_d = DW'(lnk.sin);
        ok_d      = 1'b0;
        err_d     = 1'b0;
        if (DW == 1) begin
          calc_crc_d = lfsr_sof;
          cnt_d      = CNT_CRC;
          state_d    = S_CRC;
        end else begin
          cnt_d   = CNT_DATA;
          state_d = S_DATA;
        end
      end else begin
        case (state_q)
          S_DATA: begin
            rx_data_d = (rx_data_q << 1) | DW'(lnk.sin);
            lfsr_d    = lfsr_nxt;
            if (cnt_q == CNT_ONE) begin
              calc_crc_d = lfsr_nxt;
              cnt_d      = CNT_CRC;
              state_d    = S_CRC;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          S_CRC: begin
            rx_crc_d = {rx_crc_q[PW-2:0], lnk.sin};
            if (cnt_q == CNT_ONE) begin
              done_d  = 1'b1;
              ok_d    = (rx_crc_d == calc_crc_q);
              err_d   = ~ok_d;
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lfsr_q     <= INIT;
      rx_data_q  <= '0;
      rx_crc_q   <= '0;
      calc_crc_q <= '0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      rx_data_q  <= rx_data_d;
      rx_crc_q   <= rx_crc_d;
      calc_crc_q <= calc_crc_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
    end
  end

  assign lnk.busy     = (state_q != S_IDLE);
  assign lnk.done     = done_q;
  assign lnk.crc_ok   = ok_q;
  assign lnk.crc_err  = err_q;
  assign lnk.rx_data  = rx_data_q;
  assign lnk.rx_crc   = rx_crc_q;
  assign lnk.calc_crc = calc_crc_q;

`ifdef CRC_CHK_STATS_EN
  logic        abort;
  logic [15:0] frm_cnt_q, err_cnt_q, abort_cnt_q;

  assign abort = lnk.sin_vld & lnk.sin_sof & (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      frm_cnt_q   <= '0;
      err_cnt_q   <= '0;
      abort_cnt_q <= '0;
    end else if (stats_clr) begin
      frm_cnt_q   <= '0;
      err_cnt_q   <= '0;
      abort_cnt_q <= '0;
    end else begin
      if (done_q && (frm_cnt_q != '1)) begin
        frm_cnt_q <= frm_cnt_q + 16'd1;
      end
      if (done_q && err_q && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
      if (abort && (abort_cnt_q != '1)) begin
        abort_cnt_q <= abort_cnt_q + 16'd1;
      end
    end
  end

  assign frm_cnt   = frm_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_crc_chk_serial.sv
// Self-checking bench for crc_chk_serial: frame-level reference model with per-cycle output compare
// and directed frames with hand-computed CRC-8 results.
module tb_crc_chk_serial;
  localparam int            DW   = 8;
  localparam int            PW   = 8;
  localparam logic [PW-1:0] POLY = 8'h07;
  localparam logic [PW-1:0] INIT = 8'h00;

  logic clk;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  crc_chk_serial_if #(.DW(DW), .PW(PW)) lnk ();

`ifdef CRC_CHK_STATS_EN
  logic        stats_clr;
  logic [15:0] frm_cnt, err_cnt, abort_cnt;
`endif

  crc_chk_serial #(.DW(DW), .PW(PW), .POLY(POLY), .INIT(INIT)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .lnk       (lnk.slave)
`ifdef CRC_CHK_STATS_EN
    ,
    .stats_clr (stats_clr),
    .frm_cnt   (frm_cnt),
    .err_cnt   (err_cnt),
    .abort_cnt (abort_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference CRC: remainder of (INIT*x^DW + d*x^PW) modulo the generator polynomial
  function automatic logic [PW-1:0] ref_crc(input logic [DW-1:0] d);
    logic [63:0] m, g;
    m = (64'(d) << PW) ^ (64'(INIT) << DW);
    g = (64'(1) << PW) | 64'(POLY);
    for (int k = DW + PW - 1; k >= PW; k--) begin
      if (m[k]) m = m ^ (g << (k - PW));
    end
    return m[PW-1:0];
  endfunction

  // Frame-level model: collects accepted bits, produces expected results one cycle after the last
  logic          m_active = 1'b0;
  int            m_n      = 0;
  logic [63:0]   m_word   = '0;
  logic          m_done   = 1'b0;
  logic          m_ok     = 1'b0;
  logic          m_err    = 1'b0;
  logic [DW-1:0] m_data   = '0;
  logic [PW-1:0] m_rxcrc  = '0;
  logic [PW-1:0] m_calc   = '0;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_active = 1'b0; m_n = 0; m_word = '0; m_done = 1'b0;
      m_ok = 1'b0; m_err = 1'b0; m_data = '0; m_rxcrc = '0; m_calc = '0;
    end else begin
      m_done = 1'b0;
      if (lnk.sin_vld) begin
        if (lnk.sin_sof) begin
          m_active = 1'b1; m_n = 1; m_word = 64'(lnk.sin);
        end else if (m_active) begin
          m_word = (m_word << 1) | 64'(lnk.sin); m_n++;
        end
        if (m_active && m_n == DW + PW) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_data   = m_word[PW +: DW];
          m_rxcrc  = m_word[PW-1:0];
          m_calc   = ref_crc(m_data);
          m_ok     = (m_rxcrc == m_calc);
          m_err    = !m_ok;
        end
      end
    end
  end

  int            done_cnt = 0;
  int            ok_cnt   = 0;
  logic          last_ok, last_err;
  logic [DW-1:0] last_data;
  logic [PW-1:0] last_rxcrc, last_calc;

  always @(negedge clk) begin
    chk("done", 64'(lnk.done), 64'(m_done));
    chk("busy", 64'(lnk.busy), 64'(m_active));
    if (!m_active) begin
      chk("crc_ok",   64'(lnk.crc_ok),   64'(m_ok));
      chk("crc_err",  64'(lnk.crc_err),  64'(m_err));
      chk("rx_data",  64'(lnk.rx_data),  64'(m_data));
      chk("rx_crc",   64'(lnk.rx_crc),   64'(m_rxcrc));
      chk("calc_crc", 64'(lnk.calc_crc), 64'(m_calc));
    end else begin
      chk("ok_clr",  64'(lnk.crc_ok),  64'd0);
      chk("err_clr", 64'(lnk.crc_err), 64'd0);
    end
    if (lnk.done) begin
      done_cnt++;
      if (lnk.crc_ok) ok_cnt++;
      last_ok    = lnk.crc_ok;
      last_err   = lnk.crc_err;
      last_data  = lnk.rx_data;
      last_rxcrc = lnk.rx_crc;
      last_calc  = lnk.calc_crc;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      lnk.sin_vld = 1'b0;
      lnk.sin_sof = 1'b0;
      lnk.sin     = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [DW+PW-1:0] w, input int n, input int gapmax);
    int g;
    for (int i = 0; i < n; i++) begin
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      if (i > 0) idle(g);
      @(negedge clk);
      lnk.sin     = w[DW+PW-1-i];
      lnk.sin_vld = 1'b1;
      lnk.sin_sof = (i == 0);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic [PW-1:0] c, input int gapmax);
    send_bits({d, c}, DW + PW, gapmax);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_b = 1'b0;
    lnk.sin_vld = 1'b0;
    lnk.sin_sof = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_b = 1'b1;
  endtask

  int d0, k0;

  initial begin
    rst_b       = 1'b1;
    lnk.sin     = 1'b0;
    lnk.sin_vld = 1'b0;
    lnk.sin_sof = 1'b0;
`ifdef CRC_CHK_STATS_EN
    stats_clr = 1'b0;
`endif
    #1 rst_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  64'(lnk.busy),     64'd0);
    chk("rst_done",  64'(lnk.done),     64'd0);
    chk("rst_ok",    64'(lnk.crc_ok),   64'd0);
    chk("rst_err",   64'(lnk.crc_err),  64'd0);
    chk("rst_data",  64'(lnk.rx_data),  64'd0);
    chk("rst_calc",  64'(lnk.calc_crc), 64'd0);
    @(posedge clk);
    #2 rst_b = 1'b1;

    chk("model_crc_01", 64'(ref_crc(8'h01)), 64'h07);
    chk("model_crc_ff", 64'(ref_crc(8'hFF)), 64'hF3);
    chk("model_crc_00", 64'(ref_crc(8'h00)), 64'h00);

    // 1: contiguous good frame
    d0 = done_cnt;
    send_frame(8'h01, 8'h07, 0);
    idle(3);
    chk("t1_dones", 64'(done_cnt - d0), 64'd1);
    chk("t1_ok",    64'(last_ok),       64'd1);
    chk("t1_data",  64'(last_data),     64'h01);
    chk("t1_calc",  64'(last_calc),     64'h07);

    // 2: bad CRC
    d0 = done_cnt;
    send_frame(8'hFF, 8'hF2, 0);
    idle(3);
    chk("t2_dones", 64'(done_cnt - d0), 64'd1);
    chk("t2_err",   64'(last_err),      64'd1);
    chk("t2_calc",  64'(last_calc),     64'hF3);
    chk("t2_rxcrc", 64'(last_rxcrc),    64'hF2);

    // 3: valid gaps
    d0 = done_cnt;
    send_frame(8'h01, 8'h07, 3);
    idle(3);
    chk("t3_dones", 64'(done_cnt - d0), 64'd1);
    chk("t3_ok",    64'(last_ok),       64'd1);
    chk("t3_calc",  64'(last_calc),     64'h07);

    // 4: back-to-back, B's sof lands in A's done cycle
    d0 = done_cnt; k0 = ok_cnt;
    send_frame(8'hFF, 8'hF3, 0);
    send_frame(8'h01, 8'h07, 0);
    idle(3);
    chk("t4_dones", 64'(done_cnt - d0), 64'd2);
    chk("t4_oks",   64'(ok_cnt - k0),   64'd2);
    chk("t4_data",  64'(last_data),     64'h01);

    // 5: abort after 5 data bits, then a full frame
    d0 = done_cnt;
    send_bits({8'hA5, 8'h00}, 5, 0);
    send_frame(8'h00, 8'h00, 0);
    idle(3);
    chk("t5_dones", 64'(done_cnt - d0), 64'd1);
    chk("t5_ok",    64'(last_ok),       64'd1);
    chk("t5_data",  64'(last_data),     64'h00);
`ifdef CRC_CHK_STATS_EN
    chk("t5_abort", 64'(abort_cnt), 64'd1);
    chk("t5_frm",   64'(frm_cnt),   64'd6);
    chk("t5_errc",  64'(err_cnt),   64'd1);
    @(negedge clk); stats_clr = 1'b1;
    @(negedge clk); stats_clr = 1'b0;
    chk("clr_frm",   64'(frm_cnt),   64'd0);
    chk("clr_abort", 64'(abort_cnt), 64'd0);
`endif

    // 6: reset during CRC phase
    d0 = done_cnt;
    send_bits({8'h01, 8'h07}, DW + 3, 0);
    pulse_reset();
    @(negedge clk);
    chk("t6_busy",  64'(lnk.busy),     64'd0);
    chk("t6_data",  64'(lnk.rx_data),  64'd0);
    chk("t6_rxcrc", 64'(lnk.rx_crc),   64'd0);
    chk("t6_calc",  64'(lnk.calc_crc), 64'd0);
    idle(3);
    chk("t6_nodone", 64'(done_cnt - d0), 64'd0);
    send_frame(8'h01, 8'h07, 0);
    idle(3);
    chk("t6_dones", 64'(done_cnt - d0), 64'd1);
    chk("t6_ok",    64'(last_ok),       64'd1);
    chk("t6_calc2", 64'(last_calc),     64'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
